// File: rtl/bd_chip_emulator.sv
// BD chip stand-in: echoes loopback words, applies control words, emits periodic spikes upstream.
// Optional BD_EMU_DROP_CTR_EN enables a saturating counter of unrecognised downstream words.
module bd_chip_emulator #(
  parameter int          NDN          = 21,
  parameter int          NUP          = 34,
  parameter int          ECHO_DEPTH   = 4,
  parameter int          NADDR        = 12,
  parameter logic [4:0]  ECHO_CODE    = 5'd31,
  parameter logic [4:0]  CTRL_CODE    = 5'd30,
  parameter logic [5:0]  UP_ECHO_CODE = 6'd63,
  parameter logic [5:0]  UP_SPK_CODE  = 6'd0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           p_reset,
  input  logic [NDN-1:0] dn_d,
  input  logic           dn_v,
  output logic           dn_a,
  output logic [NUP-1:0] up_d,
  output logic           up_v,
  input  logic           up_a,
  output logic [15:0]    drop_ct
);

  localparam int AW = $clog2(ECHO_DEPTH);

  logic [4:0]     code;
  logic [15:0]    payload;
  logic           accept, push, is_ctrl;

  logic [15:0]    fifo_mem [ECHO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           fifo_full, fifo_empty;

  logic           spike_en, pending, wrap;
  logic [14:0]    period, ctr;
  logic [NADDR-1:0] addr;
  logic           rr;
  logic           load, take_echo, take_spike, contended;

  assign code    = dn_d[NDN-1:NDN-5];
  assign payload = dn_d[15:0];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // During emulated chip reset every word is acked and swallowed.
  assign dn_a    = p_reset | ~fifo_full;
  assign accept  = dn_v & dn_a & ~p_reset;
  assign push    = accept & (code == ECHO_CODE);
  assign is_ctrl = accept & (code == CTRL_CODE);

  assign wrap = (period != 15'd0) && (ctr == period - 15'd1);

  // rr = 0 means the echo FIFO wins the next contended grant.
  assign load       = (~up_v | up_a) & ~p_reset;
  assign contended  = ~fifo_empty & pending;
  assign take_echo  = load & ~fifo_empty & (~pending | ~rr);
  assign take_spike = load & pending & (fifo_empty | rr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (p_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (take_echo) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= payload;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spike_en <= 1'b0;
      period   <= '0;
      ctr      <= '0;
      pending  <= 1'b0;
      addr     <= '0;
    end else if (p_reset) begin
      spike_en <= 1'b0;
      period   <= '0;
      ctr      <= '0;
      pending  <= 1'b0;
      addr     <= '0;
    end else begin
      if (is_ctrl) begin
        spike_en <= payload[0];
        period   <= payload[15:1];
        ctr      <= '0;
      end else if (wrap || period == 15'd0) begin
        ctr <= '0;
      end else begin
        ctr <= ctr + 15'd1;
      end
      // A new wrap wins over the issue of the previous spike; wraps never queue.
      if (wrap && spike_en) pending <= 1'b1;
      else if (take_spike)  pending <= 1'b0;
      if (take_spike) addr <= addr + NADDR'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_v <= 1'b0;
      up_d <= '0;
      rr   <= 1'b0;
    end else begin
      if (take_echo) begin
        up_v <= 1'b1;
        up_d <= {UP_ECHO_CODE, {(NUP-22){1'b0}}, fifo_mem[rd_ptr[AW-1:0]]};
      end else if (take_spike) begin
        up_v <= 1'b1;
        up_d <= {UP_SPK_CODE, {(NUP-6-NADDR){1'b0}}, addr};
      end else if (~up_v | up_a) begin
        up_v <= 1'b0;
      end
      if (load && contended) rr <= ~rr;
    end
  end

`ifdef BD_EMU_DROP_CTR_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = accept & (code != ECHO_CODE) & (code != CTRL_CODE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            drop_q <= '0;
    else if (p_reset)                      drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF)   drop_q <= drop_q + 16'd1;
  end

  assign drop_ct = drop_q;
`else
  assign drop_ct = 16'h0000;
`endif

endmodule

// File: tb/tb_bd_chip_emulator.sv
// Scoreboard bench for bd_chip_emulator: echo words queued on accept, spikes checked against an address model.
module tb_bd_chip_emulator;

  localparam logic [4:0] ECHO = 5'd31;
  localparam logic [4:0] CTRL = 5'd30;

  logic        clk = 1'b0;
  logic        reset, p_reset, dn_v, dn_a, up_v, up_a;
  logic [20:0] dn_d;
  logic [33:0] up_d;
  logic [15:0] drop_ct;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] echo_q[$];
  logic [11:0] spk_addr = '0;
  int          wraps = 0;
  int          up_count = 0;
  int          cyc = 0;
  bit          gap_on = 0, have_prev = 0, rec_on = 0;
  int          prev_cyc = 0, spk_in_test = 0;
  bit          kinds[$];

  bd_chip_emulator dut (
    .clk(clk), .reset(reset), .p_reset(p_reset),
    .dn_d(dn_d), .dn_v(dn_v), .dn_a(dn_a),
    .up_d(up_d), .up_v(up_v), .up_a(up_a),
    .drop_ct(drop_ct)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts and ends 1 ns after a rising edge; echo expectations are queued on the accepting edge.
  task automatic send(input logic [4:0] c, input logic [15:0] p);
    int n = 0;
    dn_d = {c, p};
    dn_v = 1'b1;
    @(negedge clk);
    while (!dn_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("dn_ack", dn_a, 1);
    @(posedge clk);
    if (dn_a && c == ECHO && !p_reset) echo_q.push_back({6'h3F, 12'h000, p});
    #1 dn_v = 1'b0;
  endtask

  // Upstream transfer monitor: sampled mid-cycle, the transfer completes on the next rising edge.
  always @(negedge clk) begin
    if (reset && up_v && up_a) begin
      up_count++;
      if (up_d[33:28] == 6'h3F) begin
        if (rec_on) kinds.push_back(1'b1);
        if (echo_q.size() == 0) check("echo_q_nonempty", 0, 1);
        else check("echo_word", up_d, echo_q.pop_front());
      end else begin
        if (rec_on) kinds.push_back(1'b0);
        check("spike_word", up_d, {6'd0, 16'd0, spk_addr});
        if (spk_addr == 12'hFFF) wraps++;
        spk_addr++;
        if (gap_on) begin
          if (have_prev) check("spike_gap", cyc - prev_cyc, 10);
          prev_cyc = cyc;
          have_prev = 1;
          spk_in_test++;
        end
      end
    end
  end

  initial begin
    int n0, viol, n_echo;
    reset = 1'b0; p_reset = 1'b0; dn_v = 1'b0; dn_d = '0; up_a = 1'b0;
    #12;
    check("rst_up_v", up_v, 0);
    check("rst_up_d", up_d, 0);
    check("rst_dn_a", dn_a, 1);
    check("rst_drop_ct", drop_ct, 0);
    @(posedge clk); #1 reset = 1'b1;
    tick(1);

    // single echo, latency
    up_a = 1'b1;
    send(ECHO, 16'hBEEF);
    check("echo_lat_n", up_v, 0);
    tick(1);
    check("echo_lat_n1_v", up_v, 1);
    check("echo_lat_n1_d", up_d, 34'h3F000BEEF);
    tick(1);
    check("echo_one_cycle", up_v, 0);

    // backpressure: 1 in output register + 4 in FIFO
    up_a = 1'b0;
    for (int i = 1; i <= 5; i++) send(ECHO, 16'h1100 + 16'(i));
    dn_d = {ECHO, 16'h1106};
    dn_v = 1'b1;
    @(negedge clk);
    check("full_dn_a", dn_a, 0);
    @(posedge clk); #1 dn_v = 1'b0;
    check("held_word", up_d, 34'h3F0001101);
    up_a = 1'b1;
    tick(12);
    check("bp_drained", echo_q.size(), 0);
    check("bp_idle", up_v, 0);

    // periodic spikes, period 10
    send(CTRL, {15'd10, 1'b1});
    gap_on = 1;
    tick(45);
    gap_on = 0;
    check("spike_count", spk_in_test, 4);
    // period 1 runs the address through its wrap
    send(CTRL, {15'd1, 1'b1});
    tick(4200);
    check("addr_wrap", wraps, 1);
    send(CTRL, 16'h0000);
    tick(6);
    check("spk_stopped", up_v, 0);

    // contention: spikes every cycle against queued echoes
    up_a = 1'b0;
    rec_on = 1;
    send(CTRL, {15'd1, 1'b1});
    for (int i = 0; i < 4; i++) send(ECHO, 16'hA000 + 16'(i));
    up_a = 1'b1;
    tick(20);
    rec_on = 0;
    send(CTRL, 16'h0000);
    tick(6);
    viol = 0; n_echo = 0;
    foreach (kinds[i]) if (kinds[i]) n_echo++;
    for (int i = 1; i < kinds.size() && n_echo > 0; i++) begin
      if (kinds[i-1]) n_echo--;
      if (n_echo > 0 && kinds[i] == kinds[i-1]) viol++;
    end
    check("alt_violations", viol, 0);
    check("contention_drained", echo_q.size(), 0);

    // emulated chip reset with held word, FIFO=3, spike pending
    up_a = 1'b0;
    for (int i = 0; i < 4; i++) send(ECHO, 16'hC000 + 16'(i));
    send(CTRL, {15'd1, 1'b1});
    tick(2);
    check("prst_held", up_d, 34'h3F000C000);
    p_reset = 1'b1;
    send(ECHO, 16'hDEAD);
    tick(1);
    p_reset = 1'b0;
    while (echo_q.size() > 1) void'(echo_q.pop_back());
    spk_addr = '0;
    n0 = up_count;
    up_a = 1'b1;
    tick(20);
    check("prst_xfers", up_count - n0, 1);
    check("prst_idle", up_v, 0);
    check("prst_q_empty", echo_q.size(), 0);

    // unrecognised codes
    n0 = up_count;
    for (int i = 1; i <= 3; i++) send(5'd7, 16'(i));
    tick(5);
`ifdef BD_EMU_DROP_CTR_EN
    check("drop_ct", drop_ct, 3);
`else
    check("drop_ct", drop_ct, 0);
`endif
    check("drop_no_up", up_count - n0, 0);

    // async reset drops an in-flight upstream word
    up_a = 1'b0;
    send(ECHO, 16'h5A5A);
    tick(2);
    check("inflight_v", up_v, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_v", up_v, 0);
    check("async_rst_d", up_d, 0);
    echo_q.delete();
    tick(1);
    reset = 1'b1;
    tick(3);
    check("post_rst_v", up_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
